rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 SHALL use `ROB_SZ, default 8: number of entries.
REQ-002 SHALL use `ROB_TAG_WIDTH, default 3: tag field width (tags 1..`ROB_SZ in a `ROB_TAG_WIDTH+1-bit field); tag 0 = invalid/none.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 resets at posedge clock).
REQ-005 SHALL have port dispatch_valid  input  1  dispatch request this cycle.
REQ-006 SHALL have port dp_packet  input  DP_PACKET  has_dest, dest_reg_idx, cond_branch, uncond_branch of the dispatching instruction.
REQ-007 SHALL have port cdb_packet  input  CDB_PACKET  rob_tag (0 = idle) and value of the completing instruction.
REQ-008 SHALL have port branch_packet  input  BRANCH_PACKET  branch_valid and rob_tag of the mispredicted branch.
REQ-009 SHALL have port map_rob_packet  input  MAP_ROB_PACKET  operand tags map_packet_a/b (rob_tag, t_plus) to be read.
REQ-010 SHALL have port rob_map_packet  output  ROB_MAP_PACKET  rob_new_tail, rob_head, tail, retire_valid.
REQ-011 SHALL have port rob_rs_packet  output  ROB_RS_PACKET  value_a, value_b, ready_a, ready_b.
REQ-012 SHALL have port retire_packet  output  ROB_RETIRE_PACKET  valid, dest_reg_idx, value to regfile.
REQ-013 SHALL have port rob_full  output  1  count == `ROB_SZ (registered state).

Function
REQ-014 SHALL hold per entry: valid, complete, has_dest, dest_reg_idx, is_branch, value; entry for tag t is stored at index t-1.
REQ-015 SHALL keep head tag, tail tag (youngest allocated), count (0..`ROB_SZ); pointers wrap `ROB_SZ -> 1.
REQ-016 SHALL drive rob_new_tail.rob_tag = tail+1 (wrapped) combinationally: the tag allocated by this cycle's dispatch.
REQ-017 SHALL accept dispatch iff dispatch_valid && !rob_full && !branch_packet.branch_valid; next cycle the entry is valid, incomplete, tail advances, count+1.
REQ-018 SHALL NOT accept dispatch when full even if a retire occurs the same cycle.
REQ-019 SHALL, when cdb_packet.rob_tag != 0 and that entry is valid, set complete and store value at posedge; CDB tags of invalid entries are ignored.
REQ-020 SHALL drive retire_valid = head entry valid && complete (registered state only; same-cycle CDB completion retires next cycle); at most one retire per cycle.
REQ-021 SHALL drive rob_head.rob_tag = head tag; on retire, invalidate the entry, advance head, count-1 at posedge.
REQ-022 SHALL drive retire_packet.valid = retire_valid && has_dest && dest_reg_idx != `ZERO_REG, with the entry's dest_reg_idx and value.
REQ-023 SHALL, on branch_valid with valid tag b, invalidate all entries strictly younger than b up to tail (wrap-aware), set tail <= b, recompute count; b itself survives.
REQ-024 SHALL allow retire and squash in the same cycle; count = surviving entries minus the retired one.
REQ-025 SHALL drive value_x/ready_x for each operand tag: ready when tag != 0 and entry complete, or cdb_packet.rob_tag equals tag this cycle (value bypassed from CDB); else ready=0, value=0.
REQ-026 SHALL be combinational for REQ-016, REQ-020, REQ-022 and REQ-025; zero-cycle read latency.

Reset
REQ-027 SHALL, on reset==0 at posedge, clear all entries, head=1, tail=`ROB_SZ, count=0; rob_full=0, retire_valid=0, retire_packet.valid=0, rob_new_tail.rob_tag=1.
REQ-028 SHALL discard any dispatch, CDB or squash presented during the reset cycle; reset mid-operation empties the buffer.

Structure
REQ-029 SHALL place `ROB_SZ, `ROB_TAG_WIDTH, ROB_MAP_PACKET, ROB_RS_PACKET, ROB_RETIRE_PACKET in sys_defs.svh.
REQ-030 SHALL be a single module; no sub-module is warranted.

Verification
REQ-031 Reset then 8 dispatches -> tags 1..8 allocated, rob_full=1 after 8th; 9th dispatch ignored, rob_new_tail.rob_tag=1.
REQ-032 CDB tag 2 value 0x55, then tag 1 value 0x11 -> retire tag 1 (0x11) one cycle after its CDB, tag 2 (0x55) the next cycle.
REQ-033 Tags 1..5 valid, branch_valid rob_tag=2 -> tail=2, count=2, next dispatch gets tag 3; CDB for tag 4 ignored.
REQ-034 Wrap: head=7, tail=2 (tags 7,8,1,2), squash at 8 -> tail=8, count=2; next alloc tag 1.
REQ-035 Operand tag 3 with CDB tag 3 value 0xAB same cycle -> ready_a=1, value_a=0xAB; tag 0 -> ready_a=0.
REQ-036 Full buffer with head complete, dispatch_valid=1 -> retire occurs, dispatch rejected; next cycle dispatch accepted.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types, sizes and tag arithmetic for the reorder buffer.
package rob_pkg;

    localparam int ROB_SZ        = 8;
    localparam int ROB_TAG_WIDTH = 3;
    localparam int TAG_W         = ROB_TAG_WIDTH + 1;
    localparam int XLEN          = 32;
    localparam int REG_IDX_W     = 5;

    typedef logic [TAG_W-1:0]         rob_tag_t;
    typedef logic [ROB_TAG_WIDTH-1:0] rob_idx_t;
    typedef logic [REG_IDX_W-1:0]     reg_idx_t;

    localparam reg_idx_t ZERO_REG  = '0;
    localparam rob_tag_t TAG_NONE  = '0;
    localparam rob_tag_t TAG_FIRST = rob_tag_t'(1);
    localparam rob_tag_t TAG_LAST  = rob_tag_t'(ROB_SZ);

    typedef struct packed {
        logic     has_dest;
        reg_idx_t dest_reg_idx;
        logic     cond_branch;
        logic     uncond_branch;
    } DP_PACKET;

    typedef struct packed {
        rob_tag_t        rob_tag;
        logic [XLEN-1:0] value;
    } CDB_PACKET;

    typedef struct packed {
        logic     branch_valid;
        rob_tag_t rob_tag;
    } BRANCH_PACKET;

    typedef struct packed {
        rob_tag_t rob_tag;
        logic     t_plus;
    } MAP_PACKET;

    typedef struct packed {
        MAP_PACKET map_packet_a;
        MAP_PACKET map_packet_b;
    } MAP_ROB_PACKET;

    typedef struct packed {
        MAP_PACKET rob_new_tail;
        MAP_PACKET rob_head;
        rob_tag_t  tail;
        logic      retire_valid;
    } ROB_MAP_PACKET;

    typedef struct packed {
        logic [XLEN-1:0] value_a;
        logic [XLEN-1:0] value_b;
        logic            ready_a;
        logic            ready_b;
    } ROB_RS_PACKET;

    typedef struct packed {
        logic            valid;
        reg_idx_t        dest_reg_idx;
        logic [XLEN-1:0] value;
    } ROB_RETIRE_PACKET;

    typedef struct packed {
        logic            valid;
        logic            complete;
        logic            has_dest;
        reg_idx_t        dest_reg_idx;
        logic            is_branch;
        logic [XLEN-1:0] value;
    } rob_entry_t;

    // Tags run 1..ROB_SZ and wrap back to 1; tag 0 means "none".
    function automatic rob_tag_t tag_inc(input rob_tag_t t);
        return (t == TAG_LAST) ? TAG_FIRST : t + TAG_FIRST;
    endfunction

    // Storage slot for a tag (tag t lives at index t-1).
    function automatic rob_idx_t tag_idx(input rob_tag_t t);
        rob_tag_t d;
        d = t - TAG_FIRST;
        return d[ROB_TAG_WIDTH-1:0];
    endfunction

    // Distance of a tag from the head, 0 = oldest; wrap-aware.
    function automatic rob_tag_t tag_age(input rob_tag_t t, input rob_tag_t head);
        return (t >= head) ? (t - head) : (t + TAG_LAST - head);
    endfunction

    function automatic logic tag_in_range(input rob_tag_t t);
        return (t != TAG_NONE) && (t <= TAG_LAST);
    endfunction

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocation at the tail, out-of-order completion
// from the CDB, in-order retirement at the head, and branch-recovery squash.
module rob
    import rob_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             dispatch_valid,
    input  DP_PACKET         dp_packet,
    input  CDB_PACKET        cdb_packet,
    input  BRANCH_PACKET     branch_packet,
    input  MAP_ROB_PACKET    map_rob_packet,
    output ROB_MAP_PACKET    rob_map_packet,
    output ROB_RS_PACKET     rob_rs_packet,
    output ROB_RETIRE_PACKET retire_packet,
    output logic             rob_full
);

    rob_entry_t entries_q [ROB_SZ];
    rob_entry_t entries_d [ROB_SZ];
    rob_tag_t   head_q, head_d;
    rob_tag_t   tail_q, tail_d;
    rob_tag_t   count_q, count_d;

    rob_tag_t    new_tail;
    rob_entry_t  head_entry;
    logic        retire;
    logic        accept;
    logic        squash;
    rob_tag_t    squash_age;
    logic [XLEN:0] lookup_a;
    logic [XLEN:0] lookup_b;
    logic        unused_bits;

    // Operand read: a CDB broadcast this cycle takes priority over stored state.
    function automatic logic [XLEN:0] operand_lookup(input rob_tag_t tag,
                                                     input rob_entry_t e,
                                                     input CDB_PACKET cdb);
        if (!tag_in_range(tag))  return '0;
        if (cdb.rob_tag == tag)  return {1'b1, cdb.value};
        if (e.complete)          return {1'b1, e.value};
        return '0;
    endfunction

    // Per-cycle control decisions derived from registered state and inputs.
    always_comb begin
        new_tail   = tag_inc(tail_q);
        head_entry = entries_q[tag_idx(head_q)];
        rob_full   = (count_q == TAG_LAST);
        retire     = head_entry.valid && head_entry.complete;
        accept     = dispatch_valid && !rob_full && !branch_packet.branch_valid;
        squash     = branch_packet.branch_valid && tag_in_range(branch_packet.rob_tag) &&
                     entries_q[tag_idx(branch_packet.rob_tag)].valid;
        squash_age = tag_age(branch_packet.rob_tag, head_q);
    end

    // Next state: completion, then squash, then retire, then allocation.
    always_comb begin
        for (int i = 0; i < ROB_SZ; i++) entries_d[i] = entries_q[i];
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (tag_in_range(cdb_packet.rob_tag) && entries_q[tag_idx(cdb_packet.rob_tag)].valid) begin
            entries_d[tag_idx(cdb_packet.rob_tag)].complete = 1'b1;
            entries_d[tag_idx(cdb_packet.rob_tag)].value    = cdb_packet.value;
        end

        // Everything younger than the branch goes; slots beyond the tail are already empty.
        if (squash) begin
            for (int i = 0; i < ROB_SZ; i++) begin
                if (tag_age(rob_tag_t'(i + 1), head_q) > squash_age) begin
                    entries_d[i].valid    = 1'b0;
                    entries_d[i].complete = 1'b0;
                end
            end
            tail_d  = branch_packet.rob_tag;
            count_d = squash_age + TAG_FIRST;
        end

        if (retire) begin
            entries_d[tag_idx(head_q)].valid    = 1'b0;
            entries_d[tag_idx(head_q)].complete = 1'b0;
            head_d  = tag_inc(head_q);
            count_d = count_d - TAG_FIRST;
        end

        if (accept) begin
            entries_d[tag_idx(new_tail)] = '{valid:        1'b1,
                                            complete:     1'b0,
                                            has_dest:     dp_packet.has_dest,
                                            dest_reg_idx: dp_packet.dest_reg_idx,
                                            is_branch:    dp_packet.cond_branch | dp_packet.uncond_branch,
                                            value:        '0};
            tail_d  = new_tail;
            count_d = count_d + TAG_FIRST;
        end
    end

    // State registers; reset empties the buffer and drops same-cycle requests.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= TAG_FIRST;
            tail_q  <= TAG_LAST;
            count_q <= '0;
            for (int i = 0; i < ROB_SZ; i++) entries_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < ROB_SZ; i++) entries_q[i] <= entries_d[i];
        end
    end

    // Zero-latency outputs to the map table, reservation stations and regfile.
    always_comb begin
        rob_map_packet.rob_new_tail = '{rob_tag: new_tail, t_plus: 1'b0};
        rob_map_packet.rob_head     = '{rob_tag: head_q, t_plus: 1'b0};
        rob_map_packet.tail         = tail_q;
        rob_map_packet.retire_valid = retire;

        lookup_a = operand_lookup(map_rob_packet.map_packet_a.rob_tag,
                                  entries_q[tag_idx(map_rob_packet.map_packet_a.rob_tag)], cdb_packet);
        lookup_b = operand_lookup(map_rob_packet.map_packet_b.rob_tag,
                                  entries_q[tag_idx(map_rob_packet.map_packet_b.rob_tag)], cdb_packet);
        rob_rs_packet.ready_a = lookup_a[XLEN];
        rob_rs_packet.value_a = lookup_a[XLEN-1:0];
        rob_rs_packet.ready_b = lookup_b[XLEN];
        rob_rs_packet.value_b = lookup_b[XLEN-1:0];

        retire_packet.valid        = retire && head_entry.has_dest && (head_entry.dest_reg_idx != ZERO_REG);
        retire_packet.dest_reg_idx = head_entry.dest_reg_idx;
        retire_packet.value        = head_entry.value;
    end

    // Branch flag and t_plus hints are carried but not consumed here.
    always_comb begin
        unused_bits = map_rob_packet.map_packet_a.t_plus ^ map_rob_packet.map_packet_b.t_plus;
        for (int i = 0; i < ROB_SZ; i++) unused_bits = unused_bits ^ entries_q[i].is_branch;
    end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios plus a randomized run
// against a queue-based model of the buffer's program-order contents.
module tb_rob;
    import rob_pkg::*;

    logic             clock;
    logic             reset;
    logic             dispatch_valid;
    DP_PACKET         dp_packet;
    CDB_PACKET        cdb_packet;
    BRANCH_PACKET     branch_packet;
    MAP_ROB_PACKET    map_rob_packet;
    ROB_MAP_PACKET    rob_map_packet;
    ROB_RS_PACKET     rob_rs_packet;
    ROB_RETIRE_PACKET retire_packet;
    logic             rob_full;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: tags in program order (oldest first) plus per-tag attributes.
    int              mq[$];
    int              m_tail;
    bit              m_cmp [ROB_SZ+1];
    logic [XLEN-1:0] m_val [ROB_SZ+1];
    bit              m_hd  [ROB_SZ+1];
    int              m_dr  [ROB_SZ+1];

    rob dut (
        .clock          (clock),
        .reset          (reset),
        .dispatch_valid (dispatch_valid),
        .dp_packet      (dp_packet),
        .cdb_packet     (cdb_packet),
        .branch_packet  (branch_packet),
        .map_rob_packet (map_rob_packet),
        .rob_map_packet (rob_map_packet),
        .rob_rs_packet  (rob_rs_packet),
        .retire_packet  (retire_packet),
        .rob_full       (rob_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int nxt(int t);
        return (t == ROB_SZ) ? 1 : t + 1;
    endfunction

    function automatic bit in_q(int t);
        foreach (mq[i]) if (mq[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_head();
        return (mq.size() > 0) ? mq[0] : nxt(m_tail);
    endfunction

    function automatic bit exp_rv();
        return (mq.size() > 0) && m_cmp[mq[0]];
    endfunction

    function automatic bit exp_ready(int t);
        if (t == 0) return 1'b0;
        if (int'(cdb_packet.rob_tag) == t) return 1'b1;
        return in_q(t) && m_cmp[t];
    endfunction

    function automatic logic [XLEN-1:0] exp_value(int t);
        if (t == 0) return '0;
        if (int'(cdb_packet.rob_tag) == t) return cdb_packet.value;
        if (in_q(t) && m_cmp[t]) return m_val[t];
        return '0;
    endfunction

    // Advance the model using the inputs held across this clock edge.
    task automatic model_step();
        bit ret, acc;
        int b, c, t;
        if (reset === 1'b0) begin
            mq.delete();
            m_tail = ROB_SZ;
            for (int i = 0; i <= ROB_SZ; i++) m_cmp[i] = 1'b0;
            return;
        end
        ret = exp_rv();
        acc = dispatch_valid && (mq.size() < ROB_SZ) && !branch_packet.branch_valid;
        c = int'(cdb_packet.rob_tag);
        if (c != 0 && in_q(c)) begin
            m_cmp[c] = 1'b1;
            m_val[c] = cdb_packet.value;
        end
        b = int'(branch_packet.rob_tag);
        if (branch_packet.branch_valid && b != 0 && in_q(b)) begin
            while (mq[$] != b) begin
                m_cmp[mq[$]] = 1'b0;
                void'(mq.pop_back());
            end
            m_tail = b;
        end
        if (ret) begin
            m_cmp[mq[0]] = 1'b0;
            void'(mq.pop_front());
        end
        if (acc) begin
            t = nxt(m_tail);
            mq.push_back(t);
            m_cmp[t] = 1'b0;
            m_hd[t]  = dp_packet.has_dest;
            m_dr[t]  = int'(dp_packet.dest_reg_idx);
            m_tail   = t;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        dispatch_valid = 1'b0;
        dp_packet      = '0;
        cdb_packet     = '0;
        branch_packet  = '0;
        map_rob_packet = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic dispatch_one(int dest);
        dispatch_valid         = 1'b1;
        dp_packet.has_dest     = 1'b1;
        dp_packet.dest_reg_idx = reg_idx_t'(dest);
        tick();
        dispatch_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset                    = 1'b0;
        dispatch_valid           = 1'b1;
        dp_packet                = '{has_dest: 1'b1, dest_reg_idx: 5'd3, cond_branch: 1'b0, uncond_branch: 1'b0};
        cdb_packet               = '{rob_tag: 4'd1, value: 32'hDEAD};
        branch_packet            = '{branch_valid: 1'b1, rob_tag: 4'd1};
        map_rob_packet           = '0;
        tick();
        idle_inputs();
        reset = 1'b1;
        #1;
        n_checks++; if (rob_full !== 1'b0) $display("FAIL reset_full got=%0b exp=0", rob_full); else n_pass++;
        n_checks++; if (rob_map_packet.retire_valid !== 1'b0) $display("FAIL reset_retire_valid got=%0b exp=0", rob_map_packet.retire_valid); else n_pass++;
        n_checks++; if (retire_packet.valid !== 1'b0) $display("FAIL reset_retire_pkt got=%0b exp=0", retire_packet.valid); else n_pass++;
        n_checks++; if (rob_map_packet.rob_new_tail.rob_tag !== 4'd1) $display("FAIL reset_new_tail got=%0d exp=1", rob_map_packet.rob_new_tail.rob_tag); else n_pass++;
        n_checks++; if (rob_map_packet.rob_head.rob_tag !== 4'd1) $display("FAIL reset_head got=%0d exp=1", rob_map_packet.rob_head.rob_tag); else n_pass++;
        n_checks++; if (rob_map_packet.tail !== 4'd8) $display("FAIL reset_tail got=%0d exp=8", rob_map_packet.tail); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= ROB_SZ; i++) begin
            dispatch_valid         = 1'b1;
            dp_packet.has_dest     = 1'b1;
            dp_packet.dest_reg_idx = reg_idx_t'(i);
            #1;
            n_checks++; if (rob_map_packet.rob_new_tail.rob_tag !== rob_tag_t'(i)) $display("FAIL fill_new_tail got=%0d exp=%0d", rob_map_packet.rob_new_tail.rob_tag, i); else n_pass++;
            n_checks++; if (rob_full !== 1'b0) $display("FAIL fill_not_full got=%0b exp=0", rob_full); else n_pass++;
            tick();
        end
        #1;
        n_checks++; if (rob_full !== 1'b1) $display("FAIL fill_full got=%0b exp=1", rob_full); else n_pass++;
        n_checks++; if (rob_map_packet.rob_new_tail.rob_tag !== 4'd1) $display("FAIL fill_ninth_tag got=%0d exp=1", rob_map_packet.rob_new_tail.rob_tag); else n_pass++;
        tick();
        dispatch_valid = 1'b0;
        #1;
        n_checks++; if (rob_map_packet.tail !== 4'd8) $display("FAIL fill_ninth_ignored got=%0d exp=8", rob_map_packet.tail); else n_pass++;
        n_checks++; if (rob_full !== 1'b1) $display("FAIL fill_still_full got=%0b exp=1", rob_full); else n_pass++;
    endtask

    task automatic test_cdb_retire();
        cdb_packet = '{rob_tag: 4'd2, value: 32'h55};
        tick();
        cdb_packet = '{rob_tag: 4'd1, value: 32'h11};
        #1;
        n_checks++; if (rob_map_packet.retire_valid !== 1'b0) $display("FAIL cdb_same_cycle_rv got=%0b exp=0", rob_map_packet.retire_valid); else n_pass++;
        tick();
        cdb_packet = '0;
        #1;
        n_checks++; if (rob_map_packet.retire_valid !== 1'b1) $display("FAIL retire1_valid got=%0b exp=1", rob_map_packet.retire_valid); else n_pass++;
        n_checks++; if (retire_packet.valid !== 1'b1) $display("FAIL retire1_pkt got=%0b exp=1", retire_packet.valid); else n_pass++;
        n_checks++; if (retire_packet.value !== 32'h11) $display("FAIL retire1_value got=%0h exp=11", retire_packet.value); else n_pass++;
        n_checks++; if (retire_packet.dest_reg_idx !== 5'd1) $display("FAIL retire1_dest got=%0d exp=1", retire_packet.dest_reg_idx); else n_pass++;
        tick();
        n_checks++; if (rob_map_packet.retire_valid !== 1'b1) $display("FAIL retire2_valid got=%0b exp=1", rob_map_packet.retire_valid); else n_pass++;
        n_checks++; if (retire_packet.value !== 32'h55) $display("FAIL retire2_value got=%0h exp=55", retire_packet.value); else n_pass++;
        n_checks++; if (rob_map_packet.rob_head.rob_tag !== 4'd2) $display("FAIL retire2_head got=%0d exp=2", rob_map_packet.rob_head.rob_tag); else n_pass++;
        tick();
        n_checks++; if (rob_map_packet.retire_valid !== 1'b0) $display("FAIL retire_done_rv got=%0b exp=0", rob_map_packet.retire_valid); else n_pass++;
        n_checks++; if (rob_map_packet.rob_head.rob_tag !== 4'd3) $display("FAIL retire_done_head got=%0d exp=3", rob_map_packet.rob_head.rob_tag); else n_pass++;
        n_checks++; if (rob_full !== 1'b0) $display("FAIL retire_done_full got=%0b exp=0", rob_full); else n_pass++;
    endtask

    task automatic test_squash();
        do_reset();
        for (int i = 1; i <= 5; i++) dispatch_one(i);
        branch_packet  = '{branch_valid: 1'b1, rob_tag: 4'd2};
        dispatch_valid = 1'b1;
        tick();
        branch_packet  = '0;
        dispatch_valid = 1'b0;
        #1;
        n_checks++; if (rob_map_packet.tail !== 4'd2) $display("FAIL squash_tail got=%0d exp=2", rob_map_packet.tail); else n_pass++;
        n_checks++; if (rob_map_packet.rob_new_tail.rob_tag !== 4'd3) $display("FAIL squash_new_tail got=%0d exp=3", rob_map_packet.rob_new_tail.rob_tag); else n_pass++;
        n_checks++; if (rob_map_packet.rob_head.rob_tag !== 4'd1) $display("FAIL squash_head got=%0d exp=1", rob_map_packet.rob_head.rob_tag); else n_pass++;
        cdb_packet = '{rob_tag: 4'd4, value: 32'h44};
        tick();
        cdb_packet = '0;
        map_rob_packet.map_packet_a.rob_tag = 4'd4;
        #1;
        n_checks++; if (rob_rs_packet.ready_a !== 1'b0) $display("FAIL squash_cdb_ignored got=%0b exp=0", rob_rs_packet.ready_a); else n_pass++;
        map_rob_packet = '0;
        dispatch_valid = 1'b1;
        #1;
        n_checks++; if (rob_map_packet.rob_new_tail.rob_tag !== 4'd3) $display("FAIL squash_realloc got=%0d exp=3", rob_map_packet.rob_new_tail.rob_tag); else n_pass++;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (rob_full !== 1'b0) $display("FAIL squash_count_early got=%0b exp=0", rob_full); else n_pass++;
            tick();
        end
        dispatch_valid = 1'b0;
        #1;
        n_checks++; if (rob_full !== 1'b1) $display("FAIL squash_count_full got=%0b exp=1", rob_full); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 1; i <= ROB_SZ; i++) dispatch_one(i);
        for (int k = 1; k <= 6; k++) begin
            cdb_packet = '{rob_tag: rob_tag_t'(k), value: XLEN'(k * 16)};
            tick();
        end
        cdb_packet = '0;
        for (int k = 0; k < 20 && rob_map_packet.rob_head.rob_tag !== 4'd7; k++) tick();
        n_checks++; if (rob_map_packet.rob_head.rob_tag !== 4'd7) $display("FAIL wrap_head_reach got=%0d exp=7", rob_map_packet.rob_head.rob_tag); else n_pass++;
        dispatch_one(9);
        dispatch_one(10);
        n_checks++; if (rob_map_packet.tail !== 4'd2) $display("FAIL wrap_tail got=%0d exp=2", rob_map_packet.tail); else n_pass++;
        branch_packet = '{branch_valid: 1'b1, rob_tag: 4'd8};
        tick();
        branch_packet = '0;
        #1;
        n_checks++; if (rob_map_packet.tail !== 4'd8) $display("FAIL wrap_squash_tail got=%0d exp=8", rob_map_packet.tail); else n_pass++;
        n_checks++; if (rob_map_packet.rob_new_tail.rob_tag !== 4'd1) $display("FAIL wrap_next_alloc got=%0d exp=1", rob_map_packet.rob_new_tail.rob_tag); else n_pass++;
        n_checks++; if (rob_map_packet.rob_head.rob_tag !== 4'd7) $display("FAIL wrap_head got=%0d exp=7", rob_map_packet.rob_head.rob_tag); else n_pass++;
        for (int i = 0; i < 5; i++) dispatch_one(i);
        n_checks++; if (rob_full !== 1'b0) $display("FAIL wrap_count_early got=%0b exp=0", rob_full); else n_pass++;
        dispatch_one(5);
        n_checks++; if (rob_full !== 1'b1) $display("FAIL wrap_count_full got=%0b exp=1", rob_full); else n_pass++;
    endtask

    task automatic test_bypass();
        do_reset();
        for (int i = 1; i <= 3; i++) dispatch_one(i);
        map_rob_packet.map_packet_a.rob_tag = 4'd3;
        map_rob_packet.map_packet_b.rob_tag = 4'd0;
        cdb_packet = '{rob_tag: 4'd3, value: 32'hAB};
        #1;
        n_checks++; if (rob_rs_packet.ready_a !== 1'b1) $display("FAIL bypass_ready got=%0b exp=1", rob_rs_packet.ready_a); else n_pass++;
        n_checks++; if (rob_rs_packet.value_a !== 32'hAB) $display("FAIL bypass_value got=%0h exp=ab", rob_rs_packet.value_a); else n_pass++;
        n_checks++; if (rob_rs_packet.ready_b !== 1'b0) $display("FAIL bypass_tag0_ready got=%0b exp=0", rob_rs_packet.ready_b); else n_pass++;
        n_checks++; if (rob_rs_packet.value_b !== 32'h0) $display("FAIL bypass_tag0_value got=%0h exp=0", rob_rs_packet.value_b); else n_pass++;
        tick();
        cdb_packet = '0;
        #1;
        n_checks++; if (rob_rs_packet.ready_a !== 1'b1) $display("FAIL stored_ready got=%0b exp=1", rob_rs_packet.ready_a); else n_pass++;
        n_checks++; if (rob_rs_packet.value_a !== 32'hAB) $display("FAIL stored_value got=%0h exp=ab", rob_rs_packet.value_a); else n_pass++;
        map_rob_packet.map_packet_a.rob_tag = 4'd0;
        #1;
        n_checks++; if (rob_rs_packet.ready_a !== 1'b0) $display("FAIL tag0_ready got=%0b exp=0", rob_rs_packet.ready_a); else n_pass++;
        map_rob_packet = '0;
    endtask

    task automatic test_full_retire();
        do_reset();
        for (int i = 1; i <= ROB_SZ; i++) dispatch_one(i);
        cdb_packet = '{rob_tag: 4'd1, value: 32'h77};
        tick();
        cdb_packet     = '0;
        dispatch_valid = 1'b1;
        #1;
        n_checks++; if (rob_map_packet.retire_valid !== 1'b1) $display("FAIL fullret_rv got=%0b exp=1", rob_map_packet.retire_valid); else n_pass++;
        n_checks++; if (rob_full !== 1'b1) $display("FAIL fullret_full got=%0b exp=1", rob_full); else n_pass++;
        tick();
        n_checks++; if (rob_full !== 1'b0) $display("FAIL fullret_rejected_full got=%0b exp=0", rob_full); else n_pass++;
        n_checks++; if (rob_map_packet.tail !== 4'd8) $display("FAIL fullret_rejected_tail got=%0d exp=8", rob_map_packet.tail); else n_pass++;
        n_checks++; if (rob_map_packet.rob_head.rob_tag !== 4'd2) $display("FAIL fullret_head got=%0d exp=2", rob_map_packet.rob_head.rob_tag); else n_pass++;
        tick();
        dispatch_valid = 1'b0;
        #1;
        n_checks++; if (rob_map_packet.tail !== 4'd1) $display("FAIL fullret_accept_tail got=%0d exp=1", rob_map_packet.tail); else n_pass++;
        n_checks++; if (rob_full !== 1'b1) $display("FAIL fullret_accept_full got=%0b exp=1", rob_full); else n_pass++;
    endtask

    task automatic test_random();
        int ta, tb, h;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            reset                  = ($urandom_range(0, 149) != 0);
            dispatch_valid         = ($urandom_range(0, 9) < 6);
            dp_packet.has_dest     = ($urandom_range(0, 3) != 0);
            dp_packet.dest_reg_idx = ($urandom_range(0, 3) == 0) ? 5'd0 : reg_idx_t'($urandom_range(1, 31));
            dp_packet.cond_branch  = $urandom_range(0, 1);
            dp_packet.uncond_branch = 1'b0;
            cdb_packet = '0;
            if ($urandom_range(0, 9) < 6) begin
                cdb_packet.rob_tag = (mq.size() > 0 && $urandom_range(0, 3) != 0) ?
                                     rob_tag_t'(mq[$urandom_range(0, mq.size() - 1)]) :
                                     rob_tag_t'($urandom_range(0, ROB_SZ));
                cdb_packet.value   = $urandom;
            end
            branch_packet = '0;
            if ($urandom_range(0, 19) == 0) begin
                branch_packet.branch_valid = 1'b1;
                branch_packet.rob_tag = (mq.size() > 0 && $urandom_range(0, 3) != 0) ?
                                        rob_tag_t'(mq[$urandom_range(0, mq.size() - 1)]) :
                                        rob_tag_t'($urandom_range(1, ROB_SZ));
            end
            ta = $urandom_range(0, ROB_SZ);
            tb = $urandom_range(0, ROB_SZ);
            map_rob_packet.map_packet_a = '{rob_tag: rob_tag_t'(ta), t_plus: 1'b0};
            map_rob_packet.map_packet_b = '{rob_tag: rob_tag_t'(tb), t_plus: 1'b0};
            #1;
            n_checks++; if (rob_full !== (mq.size() == ROB_SZ)) $display("FAIL rnd_full cyc=%0d got=%0b exp=%0b", cyc, rob_full, mq.size() == ROB_SZ); else n_pass++;
            n_checks++; if (rob_map_packet.rob_new_tail.rob_tag !== rob_tag_t'(nxt(m_tail))) $display("FAIL rnd_new_tail cyc=%0d got=%0d exp=%0d", cyc, rob_map_packet.rob_new_tail.rob_tag, nxt(m_tail)); else n_pass++;
            n_checks++; if (rob_map_packet.tail !== rob_tag_t'(m_tail)) $display("FAIL rnd_tail cyc=%0d got=%0d exp=%0d", cyc, rob_map_packet.tail, m_tail); else n_pass++;
            n_checks++; if (rob_map_packet.rob_head.rob_tag !== rob_tag_t'(exp_head())) $display("FAIL rnd_head cyc=%0d got=%0d exp=%0d", cyc, rob_map_packet.rob_head.rob_tag, exp_head()); else n_pass++;
            n_checks++; if (rob_map_packet.retire_valid !== exp_rv()) $display("FAIL rnd_retire_valid cyc=%0d got=%0b exp=%0b", cyc, rob_map_packet.retire_valid, exp_rv()); else n_pass++;
            h = exp_head();
            n_checks++; if (retire_packet.valid !== (exp_rv() && m_hd[h] && m_dr[h] != 0)) $display("FAIL rnd_retire_pkt cyc=%0d got=%0b", cyc, retire_packet.valid); else n_pass++;
            if (exp_rv()) begin
                n_checks++; if (retire_packet.value !== m_val[h]) $display("FAIL rnd_retire_value cyc=%0d got=%0h exp=%0h", cyc, retire_packet.value, m_val[h]); else n_pass++;
                n_checks++; if (retire_packet.dest_reg_idx !== reg_idx_t'(m_dr[h])) $display("FAIL rnd_retire_dest cyc=%0d got=%0d exp=%0d", cyc, retire_packet.dest_reg_idx, m_dr[h]); else n_pass++;
            end
            n_checks++; if (rob_rs_packet.ready_a !== exp_ready(ta)) $display("FAIL rnd_ready_a cyc=%0d tag=%0d got=%0b exp=%0b", cyc, ta, rob_rs_packet.ready_a, exp_ready(ta)); else n_pass++;
            n_checks++; if (rob_rs_packet.value_a !== exp_value(ta)) $display("FAIL rnd_value_a cyc=%0d tag=%0d got=%0h exp=%0h", cyc, ta, rob_rs_packet.value_a, exp_value(ta)); else n_pass++;
            n_checks++; if (rob_rs_packet.ready_b !== exp_ready(tb)) $display("FAIL rnd_ready_b cyc=%0d tag=%0d got=%0b exp=%0b", cyc, tb, rob_rs_packet.ready_b, exp_ready(tb)); else n_pass++;
            n_checks++; if (rob_rs_packet.value_b !== exp_value(tb)) $display("FAIL rnd_value_b cyc=%0d tag=%0d got=%0h exp=%0h", cyc, tb, rob_rs_packet.value_b, exp_value(tb)); else n_pass++;
            tick();
        end
        idle_inputs();
        reset = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset  = 1'b0;
        m_tail = ROB_SZ;
        test_reset();
        test_fill();
        test_cdb_retire();
        test_squash();
        test_wrap();
        test_bypass();
        test_full_retire();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
